// File: rtl/fifo_burst_reader.sv
// Read-side FIFO consumer: pops a commanded burst and streams it out through a 3-entry skid buffer.
// Optional empty-stall timeout is enabled by defining FIFO_RD_TIMEOUT_EN.
module fifo_burst_reader #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LEN_W   = 10,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             rd_clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic             rd_en_o,
    input  logic [WIDTH-1:0] rdata_i,
    input  logic             empty_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q;
    logic [LEN_W-1:0] remaining_q;
    logic             inflight_q;
    logic [WIDTH-1:0] mem_q [3];
    logic [1:0]       rd_ptr_q;
    logic [1:0]       wr_ptr_q;
    logic [1:0]       cnt_q;
    logic             done_q;
    logic             xfer;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(TIMEOUT + 1);
    logic [StallW-1:0] stall_q;
    logic              error_q;
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already popped but not yet captured still reserve a buffer slot.
    assign rd_en_o = (state_q == StRun) & ~abort_i & ~empty_i & (remaining_q != '0) &
                     ((cnt_q + {1'b0, inflight_q}) < 2'd3);

    assign m_valid_o = (cnt_q != 2'd0);
    assign m_data_o  = mem_q[rd_ptr_q];
    assign xfer      = m_valid_o & m_ready_i;
    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;

    always_ff @(posedge rd_clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
            cnt_q       <= 2'd0;
            done_q      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
`ifdef FIFO_RD_TIMEOUT_EN
            stall_q     <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            inflight_q <= rd_en_o;
`ifdef FIFO_RD_TIMEOUT_EN
            error_q    <= 1'b0;
            stall_q    <= '0;
`endif

            if (inflight_q) begin
                mem_q[wr_ptr_q] <= rdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (xfer) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (inflight_q && !xfer) begin
                cnt_q <= cnt_q + 2'd1;
            end else if (!inflight_q && xfer) begin
                cnt_q <= cnt_q - 2'd1;
            end

            if (rd_en_o) begin
                remaining_q <= remaining_q - 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            state_q     <= StRun;
                            remaining_q <= len_i;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (abort_i) begin
                        state_q <= StDrain;
                    end else if (rd_en_o && remaining_q == LEN_W'(1)) begin
                        state_q <= StDrain;
                    end
`ifdef FIFO_RD_TIMEOUT_EN
                    else if (empty_i && remaining_q != '0) begin
                        if (stall_q == StallW'(TIMEOUT - 1)) begin
                            error_q <= 1'b1;
                            state_q <= StDrain;
                        end else begin
                            stall_q <= stall_q + 1'b1;
                        end
                    end
`endif
                end
                StDrain: begin
                    if (cnt_q == 2'd0 && !inflight_q) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized self-checking bench for fifo_burst_reader against a queue-based behavioural model.
module tb_fifo_burst_reader;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned LEN_W      = 10;
    localparam int unsigned TB_TIMEOUT = 64;
    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;

    logic             rd_clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic             abort_i = 1'b0;
    logic             busy_o, done_o, error_o, rd_en_o, m_valid_o;
    logic [WIDTH-1:0] rdata_i = '0;
    logic             empty_i = 1'b1;
    logic [WIDTH-1:0] m_data_o;
    logic             m_ready_i = 1'b1;

    fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .rd_clk_i (rd_clk),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .len_i    (len_i),
        .abort_i  (abort_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .error_o  (error_o),
        .rd_en_o  (rd_en_o),
        .rdata_i  (rdata_i),
        .empty_i  (empty_i),
        .m_data_o (m_data_o),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i)
    );

    always #5 rd_clk = ~rd_clk;

    int n_chk = 0;
    int n_pass = 0;

    // Environment FIFO contents and the behavioural model of the reader.
    logic [WIDTH-1:0] fifo_q[$];
    int               m_phase = PH_IDLE;
    int               m_rem = 0;
    bit               m_infl = 0;
    logic [WIDTH-1:0] m_pipe = '0;
    logic [WIDTH-1:0] m_buf[$];
    bit               m_done_p = 0;
    bit               m_err_p = 0;
    int               m_stall = 0;

    int lit_step = -1;
    int rd_cnt = 0;
    int xfer_cnt = 0;
    int err_cnt = 0;
    bit rand_mode = 0;
    int push_pct = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit exp_rd_en();
        return m_phase == PH_RUN && !abort_i && !empty_i && m_rem != 0 &&
               (m_buf.size() + int'(m_infl)) < 3;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_error"}, error_o, 0);
        chk({tag, "_rd_en"}, rd_en_o, 0);
        chk({tag, "_m_valid"}, m_valid_o, 0);
        chk({tag, "_m_data"}, m_data_o, 0);
    endtask

    task automatic compare();
        if (rst_i) return;
        chk("rd_en", rd_en_o, exp_rd_en());
        chk("busy", busy_o, m_phase != PH_IDLE);
        chk("done", done_o, m_done_p);
        chk("error", error_o, m_err_p);
        chk("m_valid", m_valid_o, m_buf.size() != 0);
        if (m_buf.size() != 0) chk("m_data", m_data_o, m_buf[0]);
        // Hand-derived timeline of the 5-word basic burst, step 0 = start cycle.
        if (lit_step >= 0) begin
            chk("lit_rd_en", rd_en_o, lit_step >= 1 && lit_step <= 5);
            chk("lit_m_valid", m_valid_o, lit_step >= 3 && lit_step <= 7);
            if (lit_step >= 3 && lit_step <= 7)
                chk("lit_m_data", m_data_o, 8'h11 + lit_step - 3);
            chk("lit_done", done_o, lit_step == 9);
            chk("lit_busy", busy_o, lit_step >= 1 && lit_step <= 8);
            lit_step = (lit_step == 9) ? -1 : lit_step + 1;
        end
        if (rd_en_o) rd_cnt++;
        if (m_valid_o && m_ready_i) xfer_cnt++;
        if (error_o) err_cnt++;
    endtask

    task automatic advance();
        bit pop, xfer, drain_ok;
        if (rst_i) begin
            m_phase = PH_IDLE; m_rem = 0; m_infl = 0; m_buf.delete();
            m_done_p = 0; m_err_p = 0; m_stall = 0;
            return;
        end
        pop      = exp_rd_en();
        xfer     = m_buf.size() != 0 && m_ready_i;
        drain_ok = m_buf.size() == 0 && !m_infl;
        if (xfer) void'(m_buf.pop_front());
        if (m_infl) m_buf.push_back(m_pipe);
        m_infl = pop;
        if (pop) m_pipe = fifo_q.pop_front();
        m_done_p = 0;
        m_err_p  = 0;
        case (m_phase)
            PH_IDLE: if (start_i) begin
                if (len_i == 0) m_done_p = 1;
                else begin m_phase = PH_RUN; m_rem = int'(len_i); m_stall = 0; end
            end
            PH_RUN: begin
                if (abort_i) m_phase = PH_DRAIN;
                else if (pop) begin
                    m_rem--;
                    m_stall = 0;
                    if (m_rem == 0) m_phase = PH_DRAIN;
                end else if (empty_i && m_rem != 0) begin
                    m_stall++;
`ifdef FIFO_RD_TIMEOUT_EN
                    if (m_stall == TB_TIMEOUT) begin m_err_p = 1; m_phase = PH_DRAIN; end
`endif
                end else m_stall = 0;
                if (m_phase != PH_RUN) m_stall = 0;
            end
            default: if (drain_ok) begin m_phase = PH_IDLE; m_done_p = 1; end
        endcase
    endtask

    task automatic tick();
        if (push_pct > 0 && $urandom_range(99) < push_pct) fifo_q.push_back(WIDTH'($urandom));
        if (rand_mode) begin
            if (m_phase != PH_IDLE) start_i = 1'($urandom_range(1));
            abort_i   = ($urandom_range(15) == 0);
            m_ready_i = ($urandom_range(3) != 0);
        end
        empty_i = rst_i || fifo_q.size() == 0;
        rdata_i = m_infl ? m_pipe : WIDTH'($urandom);
        @(negedge rd_clk);
        compare();
        advance();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic start_burst(input int len);
        start_i = 1'b1;
        len_i   = LEN_W'(len);
        tick();
        start_i = 1'b0;
        len_i   = LEN_W'($urandom);
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while ((m_phase != PH_IDLE || m_done_p) && c < maxc) begin
            tick();
            c++;
        end
        chk("idle_bound", c < maxc, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset
        rst_i = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        rst_i = 1'b0;

        // Basic 5-word burst with literal timeline
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'h11 + 8'(i));
        m_ready_i = 1'b1;
        rd_cnt    = 0;
        lit_step  = 0;
        start_burst(5);
        wait_idle(50);
        chk("basic_pops", rd_cnt, 5);

        // Backpressure: 10 cycles of ready low
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'h20 + 8'(i));
        m_ready_i = 1'b0;
        rd_cnt    = 0;
        xfer_cnt  = 0;
        start_burst(16);
        for (int i = 0; i < 9; i++) tick();
        chk("bp_pops", rd_cnt, 3);
        m_ready_i = 1'b1;
        wait_idle(200);
        chk("bp_words", xfer_cnt, 16);

        // Empty gaps: one word every 5 cycles
        xfer_cnt = 0;
        start_burst(4);
        for (int k = 0; k < 20; k++) begin
            if (k % 5 == 0) fifo_q.push_back(8'h40 + 8'(k));
            tick();
        end
        wait_idle(50);
        chk("gap_words", xfer_cnt, 4);

        // Abort after 3 pops
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'h60 + 8'(i));
        rd_cnt   = 0;
        xfer_cnt = 0;
        start_burst(10);
        for (int i = 0; i < 20 && rd_cnt < 3; i++) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        wait_idle(50);
        chk("abort_pops", rd_cnt, 3);
        chk("abort_words", xfer_cnt, 3);
        chk("abort_left", fifo_q.size(), 7);
        fifo_q.delete();

        // Zero length
        rd_cnt = 0;
        start_burst(0);
        chk("zero_done", done_o, 1);
        tick();
        chk("zero_pops", rd_cnt, 0);

        // Reset mid-burst, then a normal burst
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h80 + 8'(i));
        start_burst(8);
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        chk_zero("mid_reset");
        rst_i    = 1'b0;
        xfer_cnt = 0;
        chk("mid_left", fifo_q.size(), 5);
        start_burst(fifo_q.size());
        wait_idle(100);
        chk("mid_words", xfer_cnt, 5);

        // Randomized bursts
        rand_mode = 1;
        push_pct  = 50;
        for (int b = 0; b < 25; b++) begin
            start_burst($urandom_range(1, 12));
            wait_idle(500);
            start_i = 1'b0;
            for (int i = 0; i < int'($urandom_range(2)); i++) tick();
        end
        rand_mode = 0;
        push_pct  = 0;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        m_ready_i = 1'b1;
        wait_idle(100);

`ifdef FIFO_RD_TIMEOUT_EN
        fifo_q.delete();
        tick();
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2);
        err_cnt  = 0;
        xfer_cnt = 0;
        start_burst(8);
        wait_idle(200);
        chk("to_error", err_cnt, 1);
        chk("to_words", xfer_cnt, 2);
`else
        chk("no_error", err_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
